// File: rtl/mario_sprite_ctrl.sv
// Big-Mario sprite sequencer: vsync-rate animation frame select plus a
// registered per-pixel ROM address with horizontal mirroring.
module mario_sprite_ctrl #(
    parameter int unsigned SPR_W           = 21,
    parameter int unsigned SPR_H           = 41,
    parameter int unsigned FRAMES_PER_STEP = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] MarioX,
    input  logic [9:0] MarioY,
    input  logic       moving,
    input  logic       airborne,
    input  logic       facing_left,
    output logic [9:0] rom_addr,
    output logic [2:0] frame_sel,
    output logic       in_sprite,
    output logic       mirror
);

    localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    typedef enum logic [2:0] {
        ST_STAND = 3'd0,
        ST_WALK1 = 3'd1,
        ST_WALK2 = 3'd2,
        ST_WALK3 = 3'd3,
        ST_JUMP  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] step_cnt;

    logic signed [10:0] dx_c;
    logic signed [10:0] dy_c;
    logic               hit_c;
    logic [9:0]         col_c;
    logic [9:0]         addr_c;

    // Animation state machine, advanced only on vsync ticks
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= ST_STAND;
            step_cnt <= '0;
            mirror   <= 1'b0;
        end else if (frame_tick) begin
            mirror <= facing_left;
            if (airborne) begin
                state    <= ST_JUMP;
                step_cnt <= '0;
            end else if (!moving) begin
                state    <= ST_STAND;
                step_cnt <= '0;
            end else begin
                case (state)
                    ST_WALK1, ST_WALK2, ST_WALK3: begin
                        if (step_cnt == CNT_LAST) begin
                            step_cnt <= '0;
                            case (state)
                                ST_WALK1: state <= ST_WALK2;
                                ST_WALK2: state <= ST_WALK3;
                                default:  state <= ST_WALK1;
                            endcase
                        end else begin
                            step_cnt <= step_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state    <= ST_WALK1;
                        step_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign frame_sel = state;

    // Signed offsets keep pixels left of / above the sprite out of the box
    always_comb begin
        dx_c   = $signed({1'b0, DrawX}) - $signed({1'b0, MarioX});
        dy_c   = $signed({1'b0, DrawY}) - $signed({1'b0, MarioY});
        hit_c  = !dx_c[10] && (dx_c[9:0] < 10'(SPR_W)) &&
                 !dy_c[10] && (dy_c[9:0] < 10'(SPR_H));
        col_c  = mirror ? (10'(SPR_W - 1) - dx_c[9:0]) : dx_c[9:0];
        addr_c = 10'(dy_c[9:0] * 10'(SPR_W)) + col_c;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rom_addr  <= '0;
            in_sprite <= 1'b0;
        end else begin
            rom_addr  <= hit_c ? addr_c : 10'd0;
            in_sprite <= hit_c;
        end
    end

endmodule

// File: tb/tb_mario_sprite_ctrl.sv
// Directed bench for mario_sprite_ctrl: address corners, mirroring,
// walk cadence, jump/landing and reset behaviour.
module tb_mario_sprite_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_tick;
    logic [9:0] DrawX, DrawY, MarioX, MarioY;
    logic       moving, airborne, facing_left;
    logic [9:0] rom_addr;
    logic [2:0] frame_sel;
    logic       in_sprite;
    logic       mirror;

    int tests_run = 0;
    int tests_failed = 0;

    mario_sprite_ctrl #(.SPR_W(21), .SPR_H(41), .FRAMES_PER_STEP(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .DrawX(DrawX), .DrawY(DrawY), .MarioX(MarioX), .MarioY(MarioY),
        .moving(moving), .airborne(airborne), .facing_left(facing_left),
        .rom_addr(rom_addr), .frame_sel(frame_sel), .in_sprite(in_sprite),
        .mirror(mirror)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock edge, then settle before sampling
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic pix(input int x, input int y, input int exp_addr, input int exp_in, input string tag);
        DrawX = 10'(x);
        DrawY = 10'(y);
        step();
        check({tag, "_addr"}, int'(rom_addr), exp_addr);
        check({tag, "_in"}, int'(in_sprite), exp_in);
    endtask

    int walk_exp[14] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 1, 1};

    initial begin
        Reset_n = 1'b0; frame_tick = 1'b0;
        DrawX = 10'd100; DrawY = 10'd0; MarioX = 10'd100; MarioY = 10'd200;
        moving = 1'b0; airborne = 1'b0; facing_left = 1'b0;

        // Reset and hold
        repeat (3) step();
        check("rst_addr", int'(rom_addr), 0);
        check("rst_in", int'(in_sprite), 0);
        check("rst_frame", int'(frame_sel), 0);
        check("rst_mirror", int'(mirror), 0);
        Reset_n = 1'b1;
        repeat (3) step();
        check("hold_frame", int'(frame_sel), 0);
        check("hold_mirror", int'(mirror), 0);
        check("hold_in", int'(in_sprite), 0);

        // Address corners, unmirrored
        pix(100, 200, 0,   1, "tl");
        pix(120, 240, 860, 1, "br");
        pix(121, 240, 0,   0, "right_out");
        pix(99,  200, 0,   0, "left_out");
        pix(110, 241, 0,   0, "below_out");
        pix(110, 199, 0,   0, "above_out");
        pix(105, 203, 3*21+5, 1, "mid");

        // Mirror latches on tick only
        facing_left = 1'b1;
        tick();
        check("mirror_set", int'(mirror), 1);
        check("mirror_stand", int'(frame_sel), 0);
        pix(100, 201, 41, 1, "mir_left");
        pix(120, 200, 0,  1, "mir_right");
        facing_left = 1'b0;
        repeat (2) step();
        check("mirror_hold", int'(mirror), 1);

        // Walk cadence
        moving = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            check($sformatf("walk%0d", i), int'(frame_sel), walk_exp[i]);
        end
        check("mirror_clear", int'(mirror), 0);
        repeat (3) step();
        check("walk_hold", int'(frame_sel), 1);
        tick(); check("walk15", int'(frame_sel), 1);
        tick(); check("walk16", int'(frame_sel), 1);
        tick(); check("walk17", int'(frame_sel), 2);

        // Jump and landing
        airborne = 1'b1;
        tick(); check("jump", int'(frame_sel), 4);
        tick(); check("jump_hold", int'(frame_sel), 4);
        airborne = 1'b0;
        tick(); check("land_moving", int'(frame_sel), 1);
        airborne = 1'b1;
        tick(); check("jump2", int'(frame_sel), 4);
        airborne = 1'b0; moving = 1'b0;
        tick(); check("land_still", int'(frame_sel), 0);

        // Reset mid-walk in WALK3 with counter=2
        moving = 1'b1;
        repeat (11) tick();
        check("pre_rst_w3", int'(frame_sel), 3);
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        check("midwalk_rst", int'(frame_sel), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rst_w1_%0d", i), int'(frame_sel), 1);
        end
        tick(); check("post_rst_w2", int'(frame_sel), 2);

        // Tick coincident with reset: reset wins
        facing_left = 1'b1;
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        check("tick_rst_frame", int'(frame_sel), 0);
        check("tick_rst_mirror", int'(mirror), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mario_sprite_ctrl.md
Name: mario_sprite_ctrl

Overview:
Per-pixel sequencer for big-Mario sprite ROMs, which are 21x41 (861 entries, 4-bit palette index, palette index 0 = transparent). It picks the animation frame (stand, walk 1-3, jump) from a vsync-rate state machine. It converts VGA DrawX/DrawY into a registered ROM read address, with horizontal mirroring for left-facing, and flags pixels inside the sprite box. It sits between the VGA controller / Mario motion logic and the ROM bank plus color mux.

Parameters:
SPR_W, 21, sprite width in pixels
SPR_H, 41, sprite height in pixels
FRAMES_PER_STEP, 4, frame_tick pulses per walk frame (>=1)

Ports:
Clk  input  1  pixel/system clock
Reset_n  input  1  synchronous reset, active-low
frame_tick  input  1  one-cycle pulse per vsync, already synchronised to Clk
DrawX  input  10  current pixel column (0-639)
DrawY  input  10  current pixel row (0-479)
MarioX  input  10  sprite top-left column
MarioY  input  10  sprite top-left row
moving  input  1  horizontal velocity nonzero
airborne  input  1  Mario not on ground
facing_left  input  1  requested facing direction
rom_addr  output  10  read address to all frame ROMs
frame_sel  output  3  0=STAND 1=WALK1 2=WALK2 3=WALK3 4=JUMP; drives ROM output mux
in_sprite  output  1  current pixel lies within the sprite box
mirror  output  1  latched facing direction

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - rom_addr=0, in_sprite=0, frame_sel=0 (STAND), mirror=0, step counter=0.
  - Reset overrides all other activity, including mid-walk and mid-jump.
- Animation FSM updates only on cycles with frame_tick=1. Otherwise state, counter and mirror hold.
- On frame_tick, first applicable rule wins:
  1. airborne=1 -> JUMP, counter=0.
  2. moving=0 -> STAND, counter=0.
  3. In STAND or JUMP with moving=1 -> WALK1, counter=0.
  4. In WALKn: if counter==FRAMES_PER_STEP-1, advance WALK1->WALK2->WALK3->WALK1 and set counter=0; else counter+1.
- Each walk frame therefore lasts exactly FRAMES_PER_STEP ticks. Landing while moving enters WALK1. Landing while still enters STAND.
- mirror <= facing_left on frame_tick only, so the sprite never flips mid-frame.
- Counter width is clog2(FRAMES_PER_STEP) with a minimum of 1. With FRAMES_PER_STEP=1, the walk frame advances on every tick.
- Address path, 1-cycle latency: rom_addr and in_sprite are registered from DrawX/DrawY/MarioX/MarioY sampled at the same edge.
  - dx = DrawX-MarioX and dy = DrawY-MarioY, computed 11-bit signed.
  - hit = (dx>=0) && (dx<SPR_W) && (dy>=0) && (dy<SPR_H).
  - col = mirror ? SPR_W-1-dx : dx. The mirror value is the registered one in effect at that cycle.
  - hit=1 -> rom_addr = dy*SPR_W + col (range 0..860), in_sprite=1.
  - hit=0 -> rom_addr=0, in_sprite=0.
- frame_sel is the FSM state register and changes one cycle after the frame_tick edge.
- Sprite partially off-screen (MarioX+SPR_W>640 or MarioY+SPR_H>480): no wrap. Pixels beyond the screen are simply never drawn.
- Transparency: the consumer treats palette index 0 as background. This block does not inspect ROM data.
- frame_tick coincident with Reset_n=0: reset wins.

Test Plan:
- Reset and hold: Reset_n=0 for 3 cycles with DrawX=MarioX=100 -> rom_addr=0, in_sprite=0, frame_sel=0, mirror=0; all hold after release with no tick.
- Address corners: MarioX=100, MarioY=200, mirror=0.
  - DrawX=100, DrawY=200 -> next cycle rom_addr=0, in_sprite=1.
  - DrawX=120, DrawY=240 -> rom_addr=860.
  - DrawX=121 or DrawX=99 -> in_sprite=0, rom_addr=0.
- Mirror: facing_left=1, one frame_tick, then DrawX=100, DrawY=201 -> rom_addr=41 (1*21+20). facing_left toggled without a tick -> mirror unchanged.
- Walk cadence: FRAMES_PER_STEP=4, moving=1, airborne=0, issue 14 ticks -> frame_sel after each tick: 1,1,1,1,2,2,2,2,3,3,3,3,1,1.
- Jump and landing: mid-WALK2 assert airborne, tick -> frame_sel=4. Clear airborne with moving=1, tick -> 1. Same with moving=0 -> 0.
- Reset mid-walk: in WALK3 with counter=2, pulse Reset_n=0 for one cycle -> frame_sel=0, counter=0. Next tick with moving=1 -> WALK1 lasting a full 4 ticks.
